// File: rtl/bit_shifter_left_seq_pkg.sv
// Shared definitions for the iterative left shifter: state encoding and
// default word/count widths used across the ALU shift path.
package bit_shifter_left_seq_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int CNT_W_DEF = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/bit_shifter_left_seq_shift_ctrl_fsm.sv
// Control FSM for the iterative shifter: owns state, remaining count,
// busy/done, and tells the datapath when to load and when to shift.
module bit_shifter_left_seq_shift_ctrl_fsm
   import bit_shifter_left_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [CNT_W-1:0] shift,
   output logic             busy,
   output logic             done,
   output logic             load,
   output logic             shift_en
);

   state_t           state;
   logic [CNT_W-1:0] count;

   // A start is only honoured while idle or in the done cycle; start during
   // SHIFT is dropped, so load and shift_en can never be active together.
   assign load     = start && ((state == ST_IDLE) || (state == ST_DONE));
   assign shift_en = (state == ST_SHIFT);

   // State, count and registered busy/done, updated together each edge.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
         count <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  count <= shift;
                  if (shift == '0) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     state <= ST_SHIFT;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end else begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b0;
               end
            end
            ST_SHIFT: begin
               // Exit on count==1 so the decrement never wraps below zero.
               count <= count - CNT_W'(1);
               if (count == CNT_W'(1)) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/bit_shifter_left_seq.sv
// Iterative left shift/rotate unit: one bit per clock under a
// start/busy/done handshake, with serial fill for multi-word shifts.
module bit_shifter_left_seq
   import bit_shifter_left_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             rotate,
   input  logic             fill,
   input  logic [CNT_W-1:0] shift,
   input  logic [WIDTH-1:0] in_data,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] out_data,
   output logic             carry_out
);

   logic [WIDTH-1:0] data_reg;
   logic             carry_reg;
   logic             mode_reg;
   logic             load;
   logic             shift_en;

   bit_shifter_left_seq_shift_ctrl_fsm #(
      .CNT_W (CNT_W)
   ) u_ctrl (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (start),
      .shift    (shift),
      .busy     (busy),
      .done     (done),
      .load     (load),
      .shift_en (shift_en)
   );

   // Operand capture on accept, then one-bit left shift per SHIFT cycle.
   // fill is sampled live each cycle; mode is frozen at accept.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_reg  <= '0;
         carry_reg <= 1'b0;
         mode_reg  <= 1'b0;
      end else if (load) begin
         data_reg  <= in_data;
         carry_reg <= 1'b0;
         mode_reg  <= rotate;
      end else if (shift_en) begin
         carry_reg <= data_reg[WIDTH-1];
         data_reg  <= {data_reg[WIDTH-2:0], mode_reg ? data_reg[WIDTH-1] : fill};
      end
   end

   assign out_data  = data_reg;
   assign carry_out = carry_reg;

endmodule

// File: tb/tb_bit_shifter_left_seq.sv
// Directed testbench for bit_shifter_left_seq with hand-computed results.
module tb_bit_shifter_left_seq;

   logic        clk;
   logic        reset_n;
   logic        start;
   logic        rotate;
   logic        fill;
   logic [3:0]  shift;
   logic [15:0] in_data;
   logic        busy;
   logic        done;
   logic [15:0] out_data;
   logic        carry_out;

   int tests_run;
   int tests_failed;
   int lat;
   int busy_cycles;
   bit saw_done;

   bit_shifter_left_seq dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .rotate    (rotate),
      .fill      (fill),
      .shift     (shift),
      .in_data   (in_data),
      .busy      (busy),
      .done      (done),
      .out_data  (out_data),
      .carry_out (carry_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests_run++;
      if (obs !== exp_v) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp_v);
      end else begin
         $display("[TB] ok   %s: %0h", tag, obs);
      end
   endtask

   // Start must already be driven; this consumes the accepting edge, then
   // counts edges (accept edge included) until done, and busy cycles seen.
   // With poke set, a stray start with junk operands is pulsed mid-shift.
   task automatic launch_wait(input bit poke);
      @(posedge clk); #1;
      start = 1'b0;
      lat = 1;
      busy_cycles = 0;
      while (!done && lat < 40) begin
         if (busy) busy_cycles++;
         if (poke && lat == 2) begin
            start   = 1'b1;
            in_data = 16'hFFFF;
            shift   = 4'd1;
            rotate  = ~rotate;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      start = 1'b0;
   endtask

   task automatic drive(input logic [15:0] d, input logic [3:0] sh, input logic rot, input logic fl);
      in_data = d;
      shift   = sh;
      rotate  = rot;
      fill    = fl;
      start   = 1'b1;
   endtask

   task automatic run_op(input string tag, input logic [15:0] d, input logic [3:0] sh,
                         input logic rot, input logic fl, input bit poke,
                         input logic [15:0] exp_d, input logic exp_c);
      @(negedge clk);
      drive(d, sh, rot, fl);
      launch_wait(poke);
      check({tag, " latency"}, lat, sh + 1);
      check({tag, " busy_cycles"}, busy_cycles, sh);
      check({tag, " out_data"}, out_data, exp_d);
      check({tag, " carry"}, carry_out, exp_c);
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      reset_n = 1'b0;
      start = 1'b1;
      rotate = 1'b0;
      fill = 1'b0;
      shift = 4'd5;
      in_data = 16'hBEEF;

      // Reset held with start asserted: everything stays cleared.
      repeat (3) @(posedge clk);
      #1;
      check("rst busy", busy, 1'b0);
      check("rst done", done, 1'b0);
      check("rst out_data", out_data, 16'h0000);
      check("rst carry", carry_out, 1'b0);
      @(negedge clk);
      start = 1'b0;
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("idle busy", busy, 1'b0);
      check("idle done", done, 1'b0);

      // Logical shifts, fill=0.
      run_op("lsl 8001", 16'h8001, 4'd4, 1'b0, 1'b0, 1'b0, 16'h0010, 1'b0);
      run_op("lsl 1801", 16'h1801, 4'd4, 1'b0, 1'b0, 1'b0, 16'h8010, 1'b1);
      // Rotate by 15 == rotate right by 1. Last bit out is original bit 1 (=1).
      run_op("rol A5C3", 16'hA5C3, 4'd15, 1'b1, 1'b0, 1'b0, {16'hA5C3 >> 1} | {16'hA5C3 << 15}, 1'b1);
      check("rol15 vs ror1 const", out_data, 16'hD2E1);
      // Zero shift and fill.
      run_op("zero", 16'h1234, 4'd0, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0);
      run_op("fill1", 16'h0000, 4'd3, 1'b0, 1'b1, 1'b0, 16'h0007, 1'b0);
      run_op("fill msb", 16'h8000, 4'd1, 1'b0, 1'b1, 1'b0, 16'h0001, 1'b1);

      // Stray start during SHIFT must be ignored.
      run_op("poke", 16'h00F1, 4'd6, 1'b0, 1'b0, 1'b1, 16'h3C40, 1'b0);

      // Back-to-back: new start held in the DONE cycle.
      run_op("b2b first", 16'h0003, 4'd2, 1'b0, 1'b0, 1'b0, 16'h000C, 1'b0);
      drive(16'h4001, 4'd3, 1'b1, 1'b0);
      launch_wait(1'b0);
      check("b2b second latency", lat, 4);
      check("b2b second out_data", out_data, 16'h000A);
      check("b2b second carry", carry_out, 1'b0);

      // Mid-operation asynchronous reset.
      @(negedge clk);
      drive(16'hFFFF, 4'd8, 1'b0, 1'b0);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #3;
      reset_n = 1'b0;
      #1;
      check("midrst busy", busy, 1'b0);
      check("midrst done", done, 1'b0);
      check("midrst out_data", out_data, 16'h0000);
      check("midrst carry", carry_out, 1'b0);
      saw_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (done) saw_done = 1'b1;
      end
      check("midrst no done", saw_done, 1'b0);
      run_op("post rst", 16'h00F0, 4'd8, 1'b1, 1'b0, 1'b0, 16'hF000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
